// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: widths, size and state
//   encodings, the pending-response record, and the byte-lane helper used
//   to decide whether an access spans two RAM words.
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    // Legacy bus-width names still used by neighbouring pipeline code.
    localparam int MemAddrBus = AW;
    localparam int InstBus    = 32;
    localparam int MemUnit    = 8;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_SPLIT2 = 1'b1
    } lsu_state_t;

    // Everything the response cycle needs to format load data.
    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] off;
        logic       split;
    } pend_t;

    // Byte lanes touched across two consecutive words; size 3 acts as word.
    function automatic logic [7:0] lane_span(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [7:0] m;
        case (size)
            LSU_SIZE_B: m = 8'h01;
            LSU_SIZE_H: m = 8'h03;
            default:    m = 8'h0F;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
//   Request/response handshake from the memory-access stage plus the data
//   RAM port of the load/store unit.
//   Request : req_valid, req_ready, req_we, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata
//   RAM     : ram_addr, ram_din, ram_cs, ram_we, ram_wem, ram_dout
//   Modports: slave = the lsu itself, master = pipeline stage + RAM side.
// ---------------------------------------------------------------------------
interface lsu_if #(
    parameter int AW = lsu_pkg::AW,
    parameter int DW = lsu_pkg::DW,
    parameter int MW = lsu_pkg::MW
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cs;
    logic          ram_we;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  ram_dout,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr, ram_din, ram_cs, ram_we, ram_wem
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output ram_dout,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, ram_din, ram_cs, ram_we, ram_wem
    );

endinterface

// File: rtl/lsu_ld_fmt.sv
// ---------------------------------------------------------------------------
// lsu_ld_fmt
//   Combinational load formatter: shifts a two-word window right by the byte
//   offset, keeps the requested number of bytes and sign/zero-extends.
//   Ports: data (64-bit window, high word = second RAM word), off, size,
//          is_unsigned, result (DW-bit extended load value).
// ---------------------------------------------------------------------------
module lsu_ld_fmt
    import lsu_pkg::*;
(
    input  logic [2*DW-1:0] data,
    input  logic [1:0]      off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [DW-1:0]   result
);

    logic [DW-1:0] win;

    always_comb begin
        win = DW'(data >> {off, 3'b000});
        case (size)
            LSU_SIZE_B: result = is_unsigned ? {{(DW-8){1'b0}}, win[7:0]}
                                             : {{(DW-8){win[7]}}, win[7:0]};
            LSU_SIZE_H: result = is_unsigned ? {{(DW-16){1'b0}}, win[15:0]}
                                             : {{(DW-16){win[15]}}, win[15:0]};
            default:    result = win;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
//   Load/store unit between the memory-access stage and the data RAM.
//   Accepts one request per cycle, converts size/offset into word-aligned
//   RAM accesses with byte write masks, splits word-crossing accesses into
//   two RAM cycles and returns extended load data one cycle after the last
//   RAM access.
//   Ports: clk, rst_n (synchronous, active-low), bus (lsu_if.slave).
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    lsu_state_t      state, state_next;
    pend_t           pend, pend_next;
    logic [DW-1:0]   hold, hold_next;
    logic            latch_en;

    logic [1:0]      off;
    logic [7:0]      lanes;
    logic            split_req;

    logic            lat_we;
    logic            lat_uns;
    logic [1:0]      lat_size;
    logic [1:0]      lat_off;
    logic [3:0]      lat_wem_hi;
    logic [AW-3:0]   lat_word;
    logic [DW-1:0]   lat_wdata;
    logic [5:0]      hi_shift;

    logic [2*DW-1:0] fmt_data;
    logic [DW-1:0]   fmt_result;

    assign off       = bus.req_addr[1:0];
    assign lanes     = lane_span(bus.req_size, off);
    assign split_req = |lanes[7:4];

    // Bytes of the store that spill into the second word sit at the top of
    // req_wdata; shifting right by 32-8*off brings them down to lane 0.
    assign hi_shift  = 6'd32 - {1'b0, lat_off, 3'b000};

    // Next state, RAM drive and the pending-response record.
    always_comb begin
        state_next    = state;
        pend_next     = '0;
        hold_next     = hold;
        latch_en      = 1'b0;
        bus.req_ready = 1'b0;
        bus.ram_cs    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_wem   = '0;
        bus.ram_addr  = '0;
        bus.ram_din   = '0;

        case (state)
            LSU_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    bus.ram_cs   = 1'b1;
                    bus.ram_we   = bus.req_we;
                    bus.ram_addr = {bus.req_addr[AW-1:2], 2'b00};
                    bus.ram_wem  = bus.req_we ? lanes[3:0] : 4'b0000;
                    bus.ram_din  = bus.req_wdata << {off, 3'b000};
                    if (split_req) begin
                        latch_en   = 1'b1;
                        state_next = LSU_SPLIT2;
                    end else begin
                        pend_next.valid       = 1'b1;
                        pend_next.is_load     = ~bus.req_we;
                        pend_next.size        = bus.req_size;
                        pend_next.is_unsigned = bus.req_unsigned;
                        pend_next.off         = off;
                        pend_next.split       = 1'b0;
                    end
                end
            end

            LSU_SPLIT2: begin
                bus.ram_cs   = 1'b1;
                bus.ram_we   = lat_we;
                bus.ram_addr = {lat_word, 2'b00} + AW'(4);
                bus.ram_wem  = lat_we ? lat_wem_hi : 4'b0000;
                bus.ram_din  = lat_wdata >> hi_shift;
                // First word of a split load arrives now; keep it for the
                // response cycle when the second word shows up.
                if (!lat_we) begin
                    hold_next = bus.ram_dout;
                end
                pend_next.valid       = 1'b1;
                pend_next.is_load     = ~lat_we;
                pend_next.size        = lat_size;
                pend_next.is_unsigned = lat_uns;
                pend_next.off         = lat_off;
                pend_next.split       = 1'b1;
                state_next            = LSU_IDLE;
            end

            default: state_next = LSU_IDLE;
        endcase

        if (!rst_n) begin
            bus.req_ready = 1'b0;
            bus.ram_cs    = 1'b0;
            bus.ram_we    = 1'b0;
            bus.ram_wem   = '0;
            latch_en      = 1'b0;
        end
    end

    // State, pending record and hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
            pend  <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            hold  <= hold_next;
        end
    end

    // Request fields needed for the second half of a split access.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_we     <= bus.req_we;
            lat_uns    <= bus.req_unsigned;
            lat_size   <= bus.req_size;
            lat_off    <= off;
            lat_wem_hi <= lanes[7:4];
            lat_word   <= bus.req_addr[AW-1:2];
            lat_wdata  <= bus.req_wdata;
        end
    end

    assign fmt_data = pend.split ? {bus.ram_dout, hold} : {{DW{1'b0}}, bus.ram_dout};

    lsu_ld_fmt u_ld_fmt (
        .data        (fmt_data),
        .off         (pend.off),
        .size        (pend.size),
        .is_unsigned (pend.is_unsigned),
        .result      (fmt_result)
    );

    assign bus.rsp_valid = rst_n & pend.valid;
    assign bus.rsp_rdata = (rst_n & pend.valid & pend.is_load) ? fmt_result : '0;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu
//   Bench for the load/store unit. A word RAM with one-cycle read latency
//   sits on the RAM port. A byte-addressed memory model predicts every load
//   result, and a queue of expected responses (due cycle + data) is checked
//   against rsp_valid/rsp_rdata on every cycle. RAM addresses alias modulo
//   1 KiB in both the RAM and the model, so any 32-bit address is usable.
// ---------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_if bus ();

    lsu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] ram_mem [256];
    logic [7:0]  bmem [1024];
    exp_t        expq [$];

    logic [31:0] obs_addr0, obs_wem0, obs_din0;
    logic [31:0] obs_addr1, obs_wem1, obs_din1, obs_ready1;
    int          acc_cyc = 0;
    logic [31:0] last_rsp = 32'h0;
    int          last_rsp_cyc = 0;
    int          rsp_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mergeWord(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [3:0] wem);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) begin
            if (wem[i]) w[8*i +: 8] = din[8*i +: 8];
        end
        return w;
    endfunction

    // Data RAM: byte-masked writes, registered reads.
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we)
                ram_mem[bus.ram_addr[9:2]] <= mergeWord(ram_mem[bus.ram_addr[9:2]],
                                                        bus.ram_din, bus.ram_wem);
            else
                bus.ram_dout <= ram_mem[bus.ram_addr[9:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian read of the byte model, then extension.
    function automatic logic [31:0] modelLoad(input logic [31:0] addr,
                                              input logic [1:0] size,
                                              input logic uns);
        int n;
        logic [31:0] v;
        logic [31:0] a;
        n = sizeBytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | ({24'h0, bmem[a[9:0]]} << (8 * i));
        end
        if (!uns) begin
            if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < sizeBytes(size); i++) begin
            a = addr + 32'(i);
            bmem[a[9:0]] = wdata[8*i +: 8];
        end
    endtask

    // Response checker: rsp_valid must be high exactly in predicted cycles.
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'h1);
            checkOutput("rsp_rdata", bus.rsp_rdata, expq[0].data);
            last_rsp     = bus.rsp_rdata;
            last_rsp_cyc = cyc;
            void'(expq.pop_front());
        end else begin
            checkOutput("rsp_valid_quiet", 32'(bus.rsp_valid), 32'h0);
        end
        if (bus.rsp_valid) rsp_run = rsp_run + 1;
        else               rsp_run = 0;
    end

    // Present one request, wait for acceptance, check the RAM accesses it
    // produces and queue the response it must generate.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic        got;
        logic [7:0]  mask8;
        logic [7:0]  lanes;
        logic        split;
        logic [31:0] waddr;
        exp_t        e;

        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;

        got = 1'b0;
        for (int w = 0; w < 8 && !got; w++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checkOutput("req_ready_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end

        mask8 = (size == 2'd0) ? 8'h01 : (size == 2'd1) ? 8'h03 : 8'h0F;
        lanes = mask8 << addr[1:0];
        split = |lanes[7:4];
        waddr = {addr[31:2], 2'b00};

        checkOutput("ram_cs0", 32'(bus.ram_cs), 32'h1);
        checkOutput("ram_we0", 32'(bus.ram_we), 32'(we));
        checkOutput("ram_addr0", bus.ram_addr, waddr);
        checkOutput("ram_wem0", 32'(bus.ram_wem), we ? 32'(lanes[3:0]) : 32'h0);
        if (we) checkOutput("ram_din0", bus.ram_din, wdata << {addr[1:0], 3'b000});
        obs_addr0 = bus.ram_addr;
        obs_wem0  = 32'(bus.ram_wem);
        obs_din0  = bus.ram_din;
        acc_cyc   = cyc;

        e.due  = cyc + (split ? 2 : 1);
        e.data = we ? 32'h0 : modelLoad(addr, size, uns);
        expq.push_back(e);
        if (we) modelStore(addr, size, wdata);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        if (split) begin
            @(negedge clk);
            checkOutput("req_ready_split", 32'(bus.req_ready), 32'h0);
            checkOutput("ram_cs1", 32'(bus.ram_cs), 32'h1);
            checkOutput("ram_we1", 32'(bus.ram_we), 32'(we));
            checkOutput("ram_addr1", bus.ram_addr, waddr + 32'd4);
            checkOutput("ram_wem1", 32'(bus.ram_wem), we ? 32'(lanes[7:4]) : 32'h0);
            if (we)
                checkOutput("ram_din1", bus.ram_din,
                            wdata >> (6'd32 - {1'b0, addr[1:0], 3'b000}));
            obs_addr1  = bus.ram_addr;
            obs_wem1   = 32'(bus.ram_wem);
            obs_din1   = bus.ram_din;
            obs_ready1 = 32'(bus.req_ready);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checkOutput("idle_cs", 32'(bus.ram_cs), 32'h0);
            checkOutput("idle_we", 32'(bus.ram_we), 32'h0);
            checkOutput("idle_wem", 32'(bus.ram_wem), 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  rsize;
        logic [31:0] raddr;

        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h100;
        bus.req_wdata    = 32'h1234_5678;

        // Reset with a request pending: nothing may leak onto the buses.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst_ram_cs", 32'(bus.ram_cs), 32'h0);
        checkOutput("rst_ram_we", 32'(bus.ram_we), 32'h0);
        checkOutput("rst_ram_wem", 32'(bus.ram_wem), 32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // Fill the whole RAM window so the model and RAM start identical.
        for (int i = 0; i < 256; i++)
            applyStimulus(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
        idleCycles(2);

        $display("[TB] aligned word store/load");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        checkOutput("sw_addr", obs_addr0, 32'h100);
        checkOutput("sw_wem", obs_wem0, 32'hF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        idleCycles(2);
        checkOutput("lw_data", last_rsp, 32'hDEAD_BEEF);
        checkOutput("lw_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);

        $display("[TB] byte lane store/load");
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5);
        checkOutput("sb_wem", obs_wem0, 32'h8);
        checkOutput("sb_din_hi", {24'h0, obs_din0[31:24]}, 32'hA5);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        idleCycles(2);
        checkOutput("lb_data", last_rsp, 32'hFFFF_FFA5);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        idleCycles(2);
        checkOutput("lbu_data", last_rsp, 32'h0000_00A5);

        $display("[TB] split word store");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h201, 32'h1122_3344);
        checkOutput("ssw_addr0", obs_addr0, 32'h200);
        checkOutput("ssw_wem0", obs_wem0, 32'hE);
        checkOutput("ssw_din0", obs_din0, 32'h2233_4400);
        checkOutput("ssw_addr1", obs_addr1, 32'h204);
        checkOutput("ssw_wem1", obs_wem1, 32'h1);
        checkOutput("ssw_din1", obs_din1, 32'h0000_0011);
        checkOutput("ssw_ready1", obs_ready1, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h201, 32'h0);
        idleCycles(3);
        checkOutput("slw_data", last_rsp, 32'h1122_3344);
        checkOutput("slw_latency", 32'(last_rsp_cyc - acc_cyc), 32'd2);

        $display("[TB] split half load");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'h8000_0000);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h104, 32'h0000_00FF);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
        idleCycles(3);
        checkOutput("lh_split", last_rsp, 32'hFFFF_FF80);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h103, 32'h0);
        idleCycles(3);
        checkOutput("lhu_split", last_rsp, 32'h0000_FF80);

        $display("[TB] address wrap-around");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hA1B2_C3D4);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h5566_7788);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
        checkOutput("wrap_addr0", obs_addr0, 32'hFFFF_FFFC);
        checkOutput("wrap_addr1", obs_addr1, 32'h0000_0000);
        idleCycles(3);
        checkOutput("wrap_data", last_rsp, 32'h7788_A1B2);

        $display("[TB] throughput");
        idleCycles(2);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("b2b_run", 32'(rsp_run), 32'd4);
        @(posedge clk);
        #1;
        idleCycles(2);

        $display("[TB] reset during split");
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'hFFFF_FFFE;
        bus.req_wdata    = 32'h0;
        @(negedge clk);
        checkOutput("rs_ready_before", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rs_ram_cs", 32'(bus.ram_cs), 32'h0);
        checkOutput("rs_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rs_req_ready_low", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rs_req_ready_after", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        idleCycles(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rsize = 2'($urandom_range(0, 3));
            raddr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            applyStimulus(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)),
                          raddr, $urandom);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        idleCycles(4);
        checkOutput("rsp_queue_drained", 32'(expq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the memory-access pipeline stage and the data `ram`. It accepts one load or store request per cycle and converts the byte/half/word size and byte offset into word-aligned RAM accesses with byte-lane write masks. Load data comes back extracted and sign- or zero-extended. Accesses that cross a 32-bit word boundary are split into two consecutive RAM accesses.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MW`, 4, byte-lane mask width (`DW/8`)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  AW  byte address
- `req_wdata`  in  DW  store data, right-justified
- `rsp_valid`  out  1  one-cycle pulse on completion of every request
- `rsp_rdata`  out  DW  extended load data; 0 for stores
- `ram_addr`  out  AW  word-aligned byte address (bits [1:0] = 0)
- `ram_din`  out  DW  lane-shifted write data
- `ram_cs`  out  1  RAM access this cycle
- `ram_we`  out  1  1 = write
- `ram_wem`  out  MW  byte-lane write mask
- `ram_dout`  in  DW  RAM read data, valid the cycle after a read

## Operation
- **Definitions**
  - `off = req_addr[1:0]`
  - `mask` = 1, 3 or F by size
  - `lanes = mask << off`, 8 bits wide
  - Split when `lanes[7:4] != 0`: half at `off` = 3, or word at `off` != 0.
- **States**
  - IDLE: `req_ready = 1`.
  - SPLIT2: `req_ready = 0`.
  - One registered pending-response record holds valid, is_load, size, unsigned, off, split, and a low-word hold register.
- **IDLE, accepted request, non-split**
  - Drive `ram_cs = 1`, `ram_we = req_we`, `ram_addr = {req_addr[AW-1:2], 2'b00}`.
  - `ram_wem = lanes[3:0]` for stores, 0 for loads.
  - `ram_din = req_wdata << 8*off`.
  - Record the pending response and stay in IDLE.
- **IDLE, accepted request, split**
  - Issue the first word with `lanes[3:0]` and the same shifted data.
  - Latch request fields and go to SPLIT2.
- **SPLIT2**
  - Issue the second access at `ram_addr + 4`, modulo 2^AW.
  - Stores: `ram_wem = lanes[7:4]`, `ram_din = req_wdata >> 8*(4-off)`.
  - Loads: capture `ram_dout` (first word) into the hold register.
  - Always return to IDLE.
- **Load formatting**
  - Form a 64-bit value: `{ram_dout, hold}` for split loads, `{32'b0, ram_dout}` otherwise.
  - Shift right by `8*off`, take `size` bytes, then sign- or zero-extend.
- **Idle bus**
  - No accepted request and not in SPLIT2: `ram_cs = 0`, `ram_we = 0`, `ram_wem = 0`.
- **Reset**
  - While `rst_n` is low, clocked: state = IDLE, pending cleared, hold = 0.
  - Reset outputs: `rsp_valid = 0`, `rsp_rdata = 0`, `ram_cs = 0`, `ram_we = 0`, `ram_wem = 0`, `req_ready = 0`.
  - Reset in SPLIT2 abandons the access; no response is produced and any half-written store is not rolled back.

## Timing
- RAM outputs are combinational from the accepted request; the RAM has one-cycle read latency.
- Non-split request accepted in cycle T: `rsp_valid` in T+1.
  - Back-to-back non-split requests sustain one per cycle.
  - A new request may be accepted in the same cycle as the previous response.
- Split request accepted in T: second access in T+1 (`req_ready = 0`), `rsp_valid` in T+2.
- `rsp_rdata` is combinational from `ram_dout` in the response cycle. The consumer cannot backpressure responses.

## Structure
- **Shared defines:** size encodings `LSU_SIZE_B/H/W`, state encodings `LSU_IDLE/LSU_SPLIT2`, `MemAddrBus`, `InstBus`, `MemUnit`.
- **Sub-module `lsu_ld_fmt`:** combinational load shift/extract/extend.
  - Inputs: 64-bit data, `off`, `size`, `unsigned`.
  - Output: DW result.

## Test plan
- **Aligned word store then load:** SW 0x100 with 0xDEADBEEF. Required in T: `ram_addr` 0x100, `ram_wem` 4'b1111, `rsp_valid` at T+1. A following LW 0x100 returns 0xDEADBEEF at T+1.
- **Byte lane store/load:** SB 0x103 with 0x000000A5. Required: `ram_wem` 4'b1000, `ram_din[31:24]` = 0xA5. LB 0x103 returns 0xFFFFFFA5; LBU 0x103 returns 0x000000A5.
- **Split word store:** SW 0x201 with 0x11223344.
  - T: addr 0x200, wem 4'b1110, din 0x22334400.
  - T+1: addr 0x204, wem 4'b0001, din 0x00000011, `req_ready` = 0.
  - `rsp_valid` at T+2; LW 0x201 then returns 0x11223344 at T+2.
- **Split half load:** mem[0x100] = 0x80000000, mem[0x104] = 0x000000FF. LH 0x103 returns 0xFFFFFF80; LHU 0x103 returns 0x0000FF80.
- **Wrap-around:** LW 0xFFFFFFFE issues 0xFFFFFFFC then 0x00000000 and assembles the result correctly.
- **Throughput and reset:** four back-to-back aligned LWs give four consecutive `rsp_valid` cycles. `rst_n` low during SPLIT2 gives `ram_cs` = 0 and `rsp_valid` = 0 on the next edge, and `req_ready` = 1 after release.
